// File: rtl/reg_file_bank.sv
// -----------------------------------------------------------------------------
// reg_file_bank
//   Multi-word register bank with one write port and two independently
//   enabled, registered read ports (A and B). Each word carries a valid bit
//   that is set when the word is written and cleared by reset. The bank sits
//   between the ALU result bus and the operand-select logic, so both ALU
//   operands can be fetched in the same cycle.
//
// Parameters
//   WIDTH : data word width in bits (>= 1)
//   DEPTH : number of words (>= 2, need not be a power of two)
//   AW    : address width, derived from DEPTH -- leave at its default
//
// Ports
//   CLK   in   clock, all state changes on the rising edge
//   CLR   in   synchronous active-low reset (clears array, valids, outputs)
//   R_W   in   1 = hold/read only, 0 = write D into word WA
//   WA    in   write address (writes to WA >= DEPTH are dropped)
//   D     in   write data
//   RA_A  in   port A read address
//   RA_B  in   port B read address
//   Ea    in   port A output enable
//   Eb    in   port B output enable
//   Qa    out  port A registered read data (0 when disabled / out of range)
//   Qb    out  port B registered read data (0 when disabled / out of range)
//   VLD_A out  valid bit of the word read on port A, aligned with Qa
//   VLD_B out  valid bit of the word read on port B, aligned with Qb
//
// Configuration
//   RF_BYPASS_EN defined   : same-edge read of the word being written returns
//                            the incoming D with valid=1 (write-first).
//   RF_BYPASS_EN undefined : same-edge read returns the pre-write contents
//                            (read-first); no bypass mux is built.
// -----------------------------------------------------------------------------
module reg_file_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             R_W,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RA_A,
  input  logic [AW-1:0]    RA_B,
  input  logic             Ea,
  input  logic             Eb,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qb,
  output logic             VLD_A,
  output logic             VLD_B
);

  // Storage and registered read outputs.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] qa_q, qa_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic             vlda_q, vlda_d;
  logic             vldb_q, vldb_d;

  // Address range checks are done at 32 bits so a non-power-of-two DEPTH
  // rejects the unused top codes of the address space.
  logic wr_en;
  logic ra_a_ok;
  logic ra_b_ok;

  assign wr_en   = !R_W && (int'(WA) < DEPTH);
  assign ra_a_ok = int'(RA_A) < DEPTH;
  assign ra_b_ok = int'(RB_sel()) < DEPTH;

  function automatic logic [AW-1:0] RB_sel();
    return RA_B;
  endfunction

  // Next-state of the two read ports: zero-gated by enable and range.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the ifs can leave a value unassigned and infer a latch.
    qa_d   = '0;
    vlda_d = 1'b0;
    qb_d   = '0;
    vldb_d = 1'b0;

    if (Ea && ra_a_ok) begin
      qa_d   = mem_q[RA_A];
      vlda_d = vld_q[RA_A];
`ifdef RF_BYPASS_EN
      // Write-first: the word being written this edge is forwarded.
      if (wr_en && (RA_A == WA)) begin
        qa_d   = D;
        vlda_d = 1'b1;
      end
`endif
    end

    if (Eb && ra_b_ok) begin
      qb_d   = mem_q[RA_B];
      vldb_d = vld_q[RA_B];
`ifdef RF_BYPASS_EN
      if (wr_en && (RA_B == WA)) begin
        qb_d   = D;
        vldb_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      // NOTE: the array itself is cleared on reset because reads of a word
      // after reset must return 0, not stale data; this costs a reset net
      // on every storage bit, which is accepted for a bank this small.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q  <= '0;
      qa_q   <= '0;
      qb_q   <= '0;
      vlda_q <= 1'b0;
      vldb_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here are what give read-first
      // behaviour: qa_d/qb_d were computed from the pre-edge array.
      if (wr_en) begin
        mem_q[WA] <= D;
        vld_q[WA] <= 1'b1;
      end
      qa_q   <= qa_d;
      qb_q   <= qb_d;
      vlda_q <= vlda_d;
      vldb_q <= vldb_d;
    end
  end

  assign Qa    = qa_q;
  assign Qb    = qb_q;
  assign VLD_A = vlda_q;
  assign VLD_B = vldb_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// -----------------------------------------------------------------------------
// tb_reg_file_bank
//   Self-checking bench for reg_file_bank. Two instances share one set of
//   inputs: DEPTH=8 (main checks) and DEPTH=6 (non-power-of-two range rules).
//   Compile with the same RF_BYPASS_EN setting as the RTL.
// -----------------------------------------------------------------------------
module tb_reg_file_bank;

  localparam int WIDTH = 16;
  localparam int AW    = 3;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             r_w;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    ra_a;
  logic [AW-1:0]    ra_b;
  logic             ea;
  logic             eb;

  logic [WIDTH-1:0] qa8, qb8, qa6, qb6;
  logic             va8, vb8, va6, vb6;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_bank #(.WIDTH(WIDTH), .DEPTH(8)) dut8 (
    .CLK(clk), .CLR(clr), .R_W(r_w), .WA(wa), .D(d),
    .RA_A(ra_a), .RA_B(ra_b), .Ea(ea), .Eb(eb),
    .Qa(qa8), .Qb(qb8), .VLD_A(va8), .VLD_B(vb8)
  );

  reg_file_bank #(.WIDTH(WIDTH), .DEPTH(6)) dut6 (
    .CLK(clk), .CLR(clr), .R_W(r_w), .WA(wa), .D(d),
    .RA_A(ra_a), .RA_B(ra_b), .Ea(ea), .Eb(eb),
    .Qa(qa6), .Qb(qb6), .VLD_A(va6), .VLD_B(vb6)
  );

  typedef struct {
    string            name;
    logic             clr;
    logic             rw;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] d;
    logic [AW-1:0]    ra_a;
    logic [AW-1:0]    ra_b;
    logic             ea;
    logic             eb;
    logic [WIDTH-1:0] eqa;
    logic [WIDTH-1:0] eqb;
    logic             eva;
    logic             evb;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: index 0 is the DEPTH=8 bank, index 1 the DEPTH=6 bank.
  logic [WIDTH-1:0] m_mem [2][8];
  logic             m_vld [2][8];
  int               m_depth [2] = '{8, 6};

  function automatic vec_t mk(string name, logic c, logic rw, int w, int dv,
                              int a, int b, logic e_a, logic e_b,
                              int xqa, int xqb, logic xva, logic xvb);
    vec_t v;
    v.name = name; v.clr = c; v.rw = rw;
    v.wa = AW'(w); v.d = WIDTH'(dv); v.ra_a = AW'(a); v.ra_b = AW'(b);
    v.ea = e_a; v.eb = e_b;
    v.eqa = WIDTH'(xqa); v.eqb = WIDTH'(xqb); v.eva = xva; v.evb = xvb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present inputs, take one rising edge, then settle before sampling.
  task automatic drive(input logic c, input logic rw, input logic [AW-1:0] w,
                       input logic [WIDTH-1:0] dv, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic e_a, input logic e_b);
    clr = c; r_w = rw; wa = w; d = dv; ra_a = a; ra_b = b; ea = e_a; eb = e_b;
    @(posedge clk);
    #1;
  endtask

  // Expected port output from the model's pre-edge state.
  task automatic predict(input int k, input logic en, input logic [AW-1:0] addr,
                         output logic [WIDTH-1:0] q, output logic v);
    q = '0;
    v = 1'b0;
    if (en && int'(addr) < m_depth[k]) begin
      if (BYPASS && !r_w && int'(wa) < m_depth[k] && addr == wa) begin
        q = d;
        v = 1'b1;
      end else begin
        q = m_mem[k][addr];
        v = m_vld[k][addr];
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] xq [2][2];
    logic             xv [2][2];

    clr = 1'b0; r_w = 1'b1; wa = '0; d = '0; ra_a = '0; ra_b = '0; ea = 1'b0; eb = 1'b0;

    // ---------------- table-driven scenarios on the DEPTH=8 bank -------------
    vecs.push_back(mk("reset",        0, 1, 0, 0,      0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("rst_rd%0d", i), 1, 1, 0, 0, i, i, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("wr3",          1, 0, 3, 'hA5A5, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("wr7",          1, 0, 7, 'h1234, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rd3_7",        1, 1, 0, 0,      3, 7, 1, 1, 'hA5A5, 'h1234, 1, 1));
    vecs.push_back(mk("rd0",          1, 1, 0, 0,      0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("gate_a",       1, 1, 0, 0,      3, 3, 0, 1, 0, 'hA5A5, 0, 1));
    vecs.push_back(mk("gate_b",       1, 1, 0, 0,      7, 7, 1, 0, 'h1234, 0, 1, 0));
    vecs.push_back(mk("wr2",          1, 0, 2, 'h00FF, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rdw2",         1, 0, 2, 'hBEEF, 2, 3, 1, 1,
                      BYPASS ? 'hBEEF : 'h00FF, 'hA5A5, 1, 1));
    vecs.push_back(mk("rd2_after",    1, 1, 0, 0,      2, 7, 1, 1, 'hBEEF, 'h1234, 1, 1));
    vecs.push_back(mk("rst_prio",     0, 0, 5, 'hFFFF, 3, 7, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rd5_post_rst", 1, 1, 0, 0,      5, 3, 1, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].rw, vecs[i].wa, vecs[i].d,
            vecs[i].ra_a, vecs[i].ra_b, vecs[i].ea, vecs[i].eb);
      check({vecs[i].name, " Qa"},    32'(qa8), 32'(vecs[i].eqa));
      check({vecs[i].name, " Qb"},    32'(qb8), 32'(vecs[i].eqb));
      check({vecs[i].name, " VLD_A"}, 32'(va8), 32'(vecs[i].eva));
      check({vecs[i].name, " VLD_B"}, 32'(vb8), 32'(vecs[i].evb));
    end

    // ---------------- hand sequence: DEPTH=6 range rules ---------------------
    drive(0, 1, 0, 0, 0, 0, 1, 1);
    check("d6 reset Qa", 32'(qa6), 32'h0);
    drive(1, 0, 5, 16'h5555, 0, 0, 0, 0);
    check("d6 wr5 gated Qa", 32'(qa6), 32'h0);
    drive(1, 0, 6, 16'h7777, 6, 5, 1, 1);
    check("d6 oor Qa",    32'(qa6), 32'h0);
    check("d6 oor VLD_A", 32'(va6), 32'h0);
    check("d6 rd5 Qb",    32'(qb6), 32'h5555);
    check("d6 rd5 VLD_B", 32'(vb6), 32'h1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0, AW'(i), 6, 1, 1);
      check($sformatf("d6 word%0d Qa", i),    32'(qa6), (i == 5) ? 32'h5555 : 32'h0);
      check($sformatf("d6 word%0d VLD_A", i), 32'(va6), (i == 5) ? 32'h1 : 32'h0);
      check($sformatf("d6 rd6 Qb %0d", i),    32'(qb6), 32'h0);
      check($sformatf("d6 rd6 VLD_B %0d", i), 32'(vb6), 32'h0);
    end

    // ---------------- randomized run on both banks vs model ------------------
    for (int cyc = 0; cyc < 400; cyc++) begin
      clr  = (cyc == 0 || $urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      r_w  = 1'($urandom_range(0, 1));
      wa   = AW'($urandom_range(0, 7));
      d    = WIDTH'($urandom);
      ra_a = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      ra_b = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      ea   = ($urandom_range(0, 4) != 0);
      eb   = ($urandom_range(0, 4) != 0);

      for (int k = 0; k < 2; k++) begin
        if (!clr) begin
          xq[k][0] = '0; xv[k][0] = 1'b0;
          xq[k][1] = '0; xv[k][1] = 1'b0;
          for (int j = 0; j < 8; j++) begin
            m_mem[k][j] = '0;
            m_vld[k][j] = 1'b0;
          end
        end else begin
          predict(k, ea, ra_a, xq[k][0], xv[k][0]);
          predict(k, eb, ra_b, xq[k][1], xv[k][1]);
          if (!r_w && int'(wa) < m_depth[k]) begin
            m_mem[k][wa] = d;
            m_vld[k][wa] = 1'b1;
          end
        end
      end

      drive(clr, r_w, wa, d, ra_a, ra_b, ea, eb);
      check($sformatf("rnd%0d d8 Qa", cyc),    32'(qa8), 32'(xq[0][0]));
      check($sformatf("rnd%0d d8 Qb", cyc),    32'(qb8), 32'(xq[0][1]));
      check($sformatf("rnd%0d d8 VLD_A", cyc), 32'(va8), 32'(xv[0][0]));
      check($sformatf("rnd%0d d8 VLD_B", cyc), 32'(vb8), 32'(xv[0][1]));
      check($sformatf("rnd%0d d6 Qa", cyc),    32'(qa6), 32'(xq[1][0]));
      check($sformatf("rnd%0d d6 Qb", cyc),    32'(qb6), 32'(xq[1][1]));
      check($sformatf("rnd%0d d6 VLD_A", cyc), 32'(va6), 32'(xv[1][0]));
      check($sformatf("rnd%0d d6 VLD_B", cyc), 32'(vb6), 32'(xv[1][1]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
